// File: rtl/uart_program_loader.sv
// UART program loader: receives a length-prefixed little-endian image over rx,
// writes it word by word into text memory and releases core_rst once complete.
module uart_program_loader #(
    parameter int CLKS_PER_BIT    = 104,
    parameter int TEXT_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    input  logic                       reload,
    output logic                       we,
    output logic [TEXT_ADDR_WIDTH-1:0] waddr,
    output logic [31:0]                wdata,
    output logic                       core_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       frame_err,
    output logic                       size_err
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT);
    localparam logic [16:0]      CAPACITY = 17'(1) << TEXT_ADDR_WIDTH;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {HDR0, HDR1, DATA, DONE} load_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t        rx_state_reg;
    logic             rx_meta_reg;
    logic             rx_sync_reg;
    logic             rx_prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             byte_valid_reg;
    logic             stop_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg   <= RX_IDLE;
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            stop_err_reg   <= 1'b0;
        end else begin
            rx_meta_reg    <= rx;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            byte_valid_reg <= 1'b0;
            stop_err_reg   <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        cnt_reg      <= CNT_W'(1);
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF_CNT) begin
                        if (rx_sync_reg) begin
                            rx_state_reg <= RX_IDLE;
                        end else begin
                            rx_state_reg <= RX_DATA;
                            cnt_reg      <= CNT_W'(1);
                            bit_idx_reg  <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == BIT_CNT) begin
                        shift_reg <= {rx_sync_reg, shift_reg[7:1]};
                        cnt_reg   <= CNT_W'(1);
                        if (bit_idx_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == BIT_CNT) begin
                        // shift_reg stays stable until the next start bit, so it doubles as the byte output
                        byte_valid_reg <= rx_sync_reg;
                        stop_err_reg   <= !rx_sync_reg;
                        rx_state_reg   <= RX_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    load_state_t                state_reg;
    logic [15:0]                count_reg;
    logic [TEXT_ADDR_WIDTH:0]   word_idx_reg;
    logic [1:0]                 lane_reg;
    logic [23:0]                word_buf_reg;
    logic                       we_reg;
    logic [TEXT_ADDR_WIDTH-1:0] waddr_reg;
    logic [31:0]                wdata_reg;
    logic                       frame_err_reg;
    logic                       size_err_reg;
    logic [15:0]                hdr_count;

    assign hdr_count = {shift_reg, count_reg[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HDR0;
            count_reg     <= '0;
            word_idx_reg  <= '0;
            lane_reg      <= '0;
            word_buf_reg  <= '0;
            we_reg        <= 1'b0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
            frame_err_reg <= 1'b0;
            size_err_reg  <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            if (stop_err_reg) begin
                frame_err_reg <= 1'b1;
            end
            case (state_reg)
                HDR0: begin
                    if (byte_valid_reg) begin
                        count_reg[7:0] <= shift_reg;
                        state_reg      <= HDR1;
                    end
                end
                HDR1: begin
                    if (stop_err_reg) begin
                        state_reg <= HDR0;
                    end else if (byte_valid_reg) begin
                        count_reg <= hdr_count;
                        if (hdr_count == 16'd0) begin
                            state_reg <= DONE;
                        end else if ({1'b0, hdr_count} > CAPACITY) begin
                            size_err_reg <= 1'b1;
                            state_reg    <= HDR0;
                        end else begin
                            word_idx_reg <= '0;
                            lane_reg     <= '0;
                            state_reg    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (stop_err_reg) begin
                        state_reg <= HDR0;
                    end else if (we_reg && 32'(word_idx_reg) == 32'(count_reg)) begin
                        // leave one cycle after the final write so done trails we
                        state_reg <= DONE;
                    end else if (byte_valid_reg) begin
                        case (lane_reg)
                            2'd0: word_buf_reg[7:0]   <= shift_reg;
                            2'd1: word_buf_reg[15:8]  <= shift_reg;
                            2'd2: word_buf_reg[23:16] <= shift_reg;
                            default: begin
                                we_reg       <= 1'b1;
                                waddr_reg    <= word_idx_reg[TEXT_ADDR_WIDTH-1:0];
                                wdata_reg    <= {shift_reg, word_buf_reg};
                                word_idx_reg <= word_idx_reg + 1'b1;
                            end
                        endcase
                        lane_reg <= lane_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (reload) begin
                        state_reg     <= HDR0;
                        frame_err_reg <= 1'b0;
                        size_err_reg  <= 1'b0;
                    end
                end
                default: state_reg <= HDR0;
            endcase
        end
    end

    assign we        = we_reg;
    assign waddr     = waddr_reg;
    assign wdata     = wdata_reg;
    assign core_rst  = (state_reg != DONE);
    assign busy      = (state_reg != DONE);
    assign done      = (state_reg == DONE);
    assign frame_err = frame_err_reg;
    assign size_err  = size_err_reg;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized bench for uart_program_loader: serial bytes are driven on rx and the
// observed writes/status are compared against a queue-based image parser.
module tb_uart_program_loader;

    localparam int CPB = 4;
    localparam int TAW = 4;
    localparam int CAP = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           rx;
    logic           reload;
    logic           we;
    logic [TAW-1:0] waddr;
    logic [31:0]    wdata;
    logic           core_rst;
    logic           busy;
    logic           done;
    logic           frame_err;
    logic           size_err;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .TEXT_ADDR_WIDTH(TAW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .reload(reload),
        .we(we), .waddr(waddr), .wdata(wdata),
        .core_rst(core_rst), .busy(busy), .done(done),
        .frame_err(frame_err), .size_err(size_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: the image is just the byte stream since the last restart.
    bit         m_done, m_ferr, m_serr;
    int         m_via_write;
    int         m_cnt;
    logic [7:0] q[$];
    int         exp_a[$];
    logic [31:0] exp_d[$];
    int         obs_a[$];
    logic [31:0] obs_d[$];

    task automatic model_reset();
        m_done = 0; m_ferr = 0; m_serr = 0;
        q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        int n, w;
        if (!ok) begin
            m_ferr = 1;
            if (!m_done) q.delete();
            return;
        end
        if (m_done) return;
        q.push_back(b);
        n = q.size();
        if (n == 2) begin
            m_cnt = {q[1], q[0]};
            if (m_cnt == 0) begin
                m_done = 1; m_via_write = 0; q.delete();
            end else if (m_cnt > CAP) begin
                m_serr = 1; q.delete();
            end
        end else if (n > 2 && (n - 2) % 4 == 0) begin
            w = (n - 2) / 4 - 1;
            exp_a.push_back(w);
            exp_d.push_back({q[n-1], q[n-2], q[n-3], q[n-4]});
            if (w + 1 == m_cnt) begin
                m_done = 1; m_via_write = 1; q.delete();
            end
        end
    endtask

    // Monitor: collect writes and note whether core_rst fell right after a write.
    logic core_rst_prev = 1'b1;
    logic we_prev = 1'b0;
    int   fall_code = -1;

    always @(negedge clk) begin
        if (we) begin
            obs_a.push_back(int'(waddr));
            obs_d.push_back(wdata);
            check_val("core_rst_at_we", 32'(core_rst), 32'd1);
        end
        if (core_rst_prev && !core_rst) fall_code = we_prev ? 1 : 0;
        core_rst_prev = core_rst;
        we_prev       = we;
    end

    task automatic check_status(input string tag);
        check_val({tag, ".core_rst"}, 32'(core_rst), 32'(!m_done));
        check_val({tag, ".busy"}, 32'(busy), 32'(!m_done));
        check_val({tag, ".done"}, 32'(done), 32'(m_done));
        check_val({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
        check_val({tag, ".size_err"}, 32'(size_err), 32'(m_serr));
    endtask

    task automatic compare_writes(input string tag);
        int a; logic [31:0] d;
        check_val({tag, ".nwrites"}, 32'(obs_a.size()), 32'(exp_a.size()));
        while (obs_a.size() > 0 && exp_a.size() > 0) begin
            a = obs_a.pop_front(); d = obs_d.pop_front();
            check_val({tag, ".waddr"}, 32'(a), 32'(exp_a.pop_front()));
            check_val({tag, ".wdata"}, d, exp_d.pop_front());
            $display("write addr %0d data %08h", a, d);
        end
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        bit was_done;
        was_done  = m_done;
        fall_code = -1;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        model_byte(b, ok);
        check_status($sformatf("byte_%02h", b));
        compare_writes("wr");
        if (!was_done && m_done) check_val("done_after_we", 32'(fall_code), 32'(m_via_write));
    endtask

    task automatic do_reset();
        rst = 1'b1; rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        if (m_done) model_reset();
        check_status("reload");
    endtask

    logic [7:0] load2[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    initial begin
        int cnt;
        rst = 1'b0; rx = 1'b1; reload = 1'b0;
        @(negedge clk);

        do_reset();
        check_status("reset");
        check_val("reset.we", 32'(we), 32'd0);
        check_val("reset.waddr", 32'(waddr), 32'd0);
        check_val("reset.wdata", wdata, 32'd0);

        for (int i = 0; i < 10; i++) send_byte(load2[i], 1'b1);
        check_val("load2.done", 32'(done), 32'd1);
        do_reload();

        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
        do_reload();

        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
        do_reload();

        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (8 * CPB) @(negedge clk);
        check_status("glitch");
        compare_writes("glitch");
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        do_reload();

        // Randomized loads, including oversize headers and occasional framing errors.
        for (int it = 0; it < 8; it++) begin
            cnt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 5));
            send_byte(8'(cnt), 1'b1);
            send_byte(8'h00, 1'b1);
            if (!m_serr) begin
                for (int k = 0; k < 4 * cnt; k++) send_byte(8'($urandom), $urandom_range(0, 24) != 0);
            end
            if (m_done) do_reload();
            else do_reset();
        end

        // Reset in the middle of the last byte of a word: nothing must be written.
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_val("midrst.we", 32'(we), 32'd0);
        check_val("midrst.waddr", 32'(waddr), 32'd0);
        repeat (8 * CPB) @(negedge clk);
        check_status("midrst");
        compare_writes("midrst");
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Loads a program image over a UART serial line into the core's instruction text memory and holds the core in reset until the image is complete. Sits directly upstream of the pipelined core: its write port drives the text memory's write side, and its `core_rst` output drives the core's `rst`. It allows new programs to be loaded on the board without resynthesis.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200). Legal values are ≥ 4.
- `TEXT_ADDR_WIDTH`, default 12: word-address width of text memory. Capacity is 2^TEXT_ADDR_WIDTH words.

**Ports.** One clock; reset is synchronous and active-high.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: UART receive line. Asynchronous; idles high.
- `reload`, input, 1: single-cycle pulse. Restarts loading from the DONE state.
- `we`, output, 1: text-memory write enable, one-cycle pulse per word.
- `waddr`, output, TEXT_ADDR_WIDTH: text-memory word address.
- `wdata`, output, 32: instruction word.
- `core_rst`, output, 1: reset to the core. High at all times except in DONE.
- `busy`, output, 1: high while in the HDR0, HDR1 or DATA states.
- `done`, output, 1: high in the DONE state.
- `frame_err`, output, 1: sticky. Set by a stop bit of 0.
- `size_err`, output, 1: sticky. Set when the header count exceeds capacity.

## Operation

**Receiver**
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Start detection: a synchronized 1→0 transition while the receiver is idle.
- Start bit is re-sampled at `CLKS_PER_BIT/2` (integer divide).
  - If it reads 1, this is a false start and the receiver returns to idle.
- 8 data bits, LSB first, each sampled `CLKS_PER_BIT` cycles after the previous sample.
- Stop bit is sampled `CLKS_PER_BIT` cycles after data bit 7.
  - Stop = 1: internal `byte_valid` pulses for 1 cycle with the byte.
  - Stop = 0: `frame_err` is set and no byte is produced.
- The receiver returns to idle immediately after the stop sample.

**Loader FSM** (states HDR0, HDR1, DATA, DONE)
- HDR0: the received byte becomes `count[7:0]`. Go to HDR1.
- HDR1: the received byte becomes `count[15:8]`. Then:
  - `count == 0`: go to DONE.
  - `count > 2^TEXT_ADDR_WIDTH`: set `size_err`, go to HDR0.
  - Otherwise: clear the word index and byte lane, then go to DATA.
- DATA: bytes are little-endian. Lane 0 → `wdata[7:0]` … lane 3 → `wdata[31:24]`.
  - On lane 3, `we` pulses with `waddr` = word index.
  - The word index then increments and the lane wraps to 0.
  - After the write of word `count-1`, go to DONE.
- DONE: `core_rst` = 0. Received bytes are ignored.
  - `reload` → HDR0. Both error flags clear and `core_rst` = 1 from the next cycle.
- Framing error in any of HDR0, HDR1 or DATA: abort to HDR0, discarding the partial word and count.
- `reload` outside DONE is ignored.
- `frame_err` and `size_err` clear only on `rst` or on an accepted `reload`.

**Arithmetic**
- `count` is 16 bits unsigned.
- The word index is TEXT_ADDR_WIDTH+1 bits, so a full-capacity load does not wrap before the compare.
- `waddr` is the low TEXT_ADDR_WIDTH bits of the word index.

## Timing

**Reset values**
- State: HDR0.
- `we` = 0, `waddr` = 0, `wdata` = 0.
- `core_rst` = 1, `busy` = 1, `done` = 0, `frame_err` = 0, `size_err` = 0.
- Receiver: idle.

**Latencies**
- `rx` edge → synchronized: 2 cycles.
- `byte_valid` is registered 1 cycle after the stop-bit sample.
- `we`, `waddr` and `wdata` are registered and valid together in the cycle after lane-3 `byte_valid`. `wdata` holds its value until the next write.
- `core_rst` falls, and `done` rises, in the cycle after the final `we`. For `count == 0`, this is the cycle after the HDR1 `byte_valid`.
- A full byte takes about 10·`CLKS_PER_BIT` cycles. There is no back-pressure: text memory accepts a write every cycle.

**Boundary cases**
- `rst` during a byte or mid-load: next cycle is in the reset state; the partial word is lost and words already written stay in memory.
- `reload` and a `byte_valid` in the same cycle in DONE: `reload` wins and the byte is discarded.
- A false start (glitch shorter than `CLKS_PER_BIT/2`) produces no byte and no error.

## Test plan

All scenarios use `CLKS_PER_BIT` = 4 and `TEXT_ADDR_WIDTH` = 4.

1. **Reset.** Assert `rst` for 2 cycles, `rx` = 1.
   - Expect `core_rst` = 1, `busy` = 1, `we` = 0, both errors = 0.
2. **Two-word load.** Send 02 00 13 05 10 00 93 05 20 00.
   - Expect `we` at `waddr` 0 with `wdata` = 0x00100513, then `waddr` 1 with `wdata` = 0x00200593.
   - `core_rst` falls 1 cycle after the second `we`; `done` = 1.
3. **Size error.** Send header 11 00 (17 > 16).
   - Expect `size_err` = 1, state HDR0, no `we`.
   - Then header 01 00 plus one word loads normally.
4. **Framing error.** Send header 02 00, one byte with stop = 0, then a valid 1-word load.
   - Expect `frame_err` = 1, the load aborted, and the retry writes `waddr` 0.
5. **Glitch and zero count.** 1-cycle low glitch on `rx`: expect no byte and no error.
   - Header 00 00: expect DONE with zero `we` pulses.
6. **Reload and reset mid-load.** In DONE, pulse `reload`.
   - Expect `core_rst` = 1 and errors cleared next cycle.
   - Then assert `rst` mid-word: expect the partial word is not written.
